// File: rtl/leaf_stream_bridge_if.sv
// Stream handshake bundle between leaf_interface, leaf_stream_bridge and the HLS kernel.
// Buses are flattened with port 0 in the LSBs.
interface leaf_stream_bridge_if #(
   parameter int NUM_IN_PORTS  = 1,
   parameter int NUM_OUT_PORTS = 1,
   parameter int PAYLOAD_BITS  = 32
);
   logic [PAYLOAD_BITS*NUM_IN_PORTS-1:0]  din_iface;
   logic [NUM_IN_PORTS-1:0]               vld_iface;
   logic [NUM_IN_PORTS-1:0]               ack_to_iface;
   logic [PAYLOAD_BITS*NUM_IN_PORTS-1:0]  dout_user;
   logic [NUM_IN_PORTS-1:0]               vld_to_user;
   logic [NUM_IN_PORTS-1:0]               ack_from_user;
   logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0] din_user;
   logic [NUM_OUT_PORTS-1:0]              vld_from_user;
   logic [NUM_OUT_PORTS-1:0]              ack_to_user;
   logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0] dout_iface;
   logic [NUM_OUT_PORTS-1:0]              vld_to_iface;
   logic [NUM_OUT_PORTS-1:0]              ack_from_iface;

   modport slave (
      input  din_iface, vld_iface, ack_from_user, din_user, vld_from_user, ack_from_iface,
      output ack_to_iface, dout_user, vld_to_user, ack_to_user, dout_iface, vld_to_iface
   );

   modport master (
      output din_iface, vld_iface, ack_from_user, din_user, vld_from_user, ack_from_iface,
      input  ack_to_iface, dout_user, vld_to_user, ack_to_user, dout_iface, vld_to_iface
   );
endinterface

// File: rtl/leaf_stream_bridge.sv
// Per-port FIFO decoupling between leaf_interface and an HLS kernel, with an
// ap_start run FSM and debug word/run counters.
module leaf_stream_bridge_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_vld,
   output logic             wr_ack,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_vld,
   input  logic             rd_ack,
   output logic             pop
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      used_s;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] head_q, head_d;
   logic             vld_q, vld_d, ack_q, ack_d;
   logic             push_s, pop_s;

   assign push_s  = wr_vld & ack_q & ~flush;
   assign pop_s   = vld_q & rd_ack & ~flush;
   assign used_s  = wr_ptr_q - rd_ptr_q;
   assign wr_ack  = ack_q & ~flush;
   assign rd_vld  = vld_q & ~flush;
   assign rd_data = head_q;
   assign pop     = pop_s;

   // Head and valid only count words stored before this edge: one cycle of fall-through.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      vld_d    = vld_q;
      ack_d    = ack_q;
      head_d   = head_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         vld_d    = 1'b0;
         ack_d    = 1'b1;
         head_d   = '0;
      end else begin
         if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
         else        wr_ptr_d = wr_ptr_q;
         if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         else        rd_ptr_d = rd_ptr_q;
         vld_d  = used_s > {{AW{1'b0}}, pop_s};
         head_d = mem_q[rd_ptr_d[AW-1:0]];
         ack_d  = !((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= 1'b0;
         ack_q    <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         vld_q    <= vld_d;
         ack_q    <= ack_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_s) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end
endmodule

module leaf_stream_bridge #(
   parameter int NUM_IN_PORTS  = 1,
   parameter int NUM_OUT_PORTS = 1,
   parameter int PAYLOAD_BITS  = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int AUTO_RESTART  = 0,
   parameter int CNT_BITS      = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush,
   leaf_stream_bridge_if.slave               bus,
   input  logic                              start_req,
   output logic                              ap_start,
   input  logic                              ap_done,
   output logic                              busy,
   output logic [CNT_BITS*NUM_IN_PORTS-1:0]  in_count,
   output logic [CNT_BITS*NUM_OUT_PORTS-1:0] out_count,
   output logic [CNT_BITS-1:0]               run_count
);
   localparam int PB = PAYLOAD_BITS;
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   logic [NUM_IN_PORTS-1:0]                in_pop_s;
   logic [NUM_OUT_PORTS-1:0]               out_pop_s;
   logic [NUM_IN_PORTS-1:0][CNT_BITS-1:0]  in_cnt_q, in_cnt_d;
   logic [NUM_OUT_PORTS-1:0][CNT_BITS-1:0] out_cnt_q, out_cnt_d;
   logic [CNT_BITS-1:0]                    run_cnt_q, run_cnt_d;
   state_t                                 state_q, state_d;
   logic                                   busy_q, busy_d;

   for (genvar g = 0; g < NUM_IN_PORTS; g++) begin : g_in
      leaf_stream_bridge_fifo #(.WIDTH(PB), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .flush   (flush),
         .wr_data (bus.din_iface[g*PB +: PB]),
         .wr_vld  (bus.vld_iface[g]),
         .wr_ack  (bus.ack_to_iface[g]),
         .rd_data (bus.dout_user[g*PB +: PB]),
         .rd_vld  (bus.vld_to_user[g]),
         .rd_ack  (bus.ack_from_user[g]),
         .pop     (in_pop_s[g])
      );
   end

   for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_out
      leaf_stream_bridge_fifo #(.WIDTH(PB), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .flush   (flush),
         .wr_data (bus.din_user[g*PB +: PB]),
         .wr_vld  (bus.vld_from_user[g]),
         .wr_ack  (bus.ack_to_user[g]),
         .rd_data (bus.dout_iface[g*PB +: PB]),
         .rd_vld  (bus.vld_to_iface[g]),
         .rd_ack  (bus.ack_from_iface[g]),
         .pop     (out_pop_s[g])
      );
   end

   always_comb begin
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      for (int k = 0; k < NUM_IN_PORTS; k++) begin
         if (flush)            in_cnt_d[k] = '0;
         else if (in_pop_s[k]) in_cnt_d[k] = in_cnt_q[k] + CNT_ONE;
         else                  in_cnt_d[k] = in_cnt_q[k];
      end
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
         if (flush)             out_cnt_d[k] = '0;
         else if (out_pop_s[k]) out_cnt_d[k] = out_cnt_q[k] + CNT_ONE;
         else                   out_cnt_d[k] = out_cnt_q[k];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   // Flush clears the run counter but never moves the run state.
   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_req) state_d = ST_RUN;
            else           state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (ap_done) begin
               run_cnt_d = run_cnt_q + CNT_ONE;
               if ((AUTO_RESTART != 0) && start_req) state_d = ST_RUN;
               else                                  state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) run_cnt_d = '0;
      else       run_cnt_d = run_cnt_d;
      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         run_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         run_cnt_q <= run_cnt_d;
      end
   end

   assign ap_start  = busy_q;
   assign busy      = busy_q;
   assign in_count  = in_cnt_q;
   assign out_count = out_cnt_q;
   assign run_count = run_cnt_q;
endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Scoreboard bench: instance A (3 in / 2 out, one-shot) covers streaming, flush and reset;
// instance B (1 in / 1 out, auto-restart) covers the restart behaviour of ap_start.
module tb_leaf_stream_bridge;
   localparam int PB = 32;
   localparam int CB = 16;
   localparam int NI = 3;
   localparam int NO = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic flush_a, start_req_a, ap_done_a, ap_start_a, busy_a;
   logic flush_b, start_req_b, ap_done_b, ap_start_b, busy_b;
   logic [CB*NI-1:0] in_count_a;
   logic [CB*NO-1:0] out_count_a;
   logic [CB-1:0]    run_count_a;
   logic [CB-1:0]    in_count_b, out_count_b, run_count_b;

   always #5 clk = ~clk;

   leaf_stream_bridge_if #(.NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .PAYLOAD_BITS(PB)) bus_a ();
   leaf_stream_bridge_if #(.NUM_IN_PORTS(1), .NUM_OUT_PORTS(1), .PAYLOAD_BITS(PB)) bus_b ();

   leaf_stream_bridge #(.NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .PAYLOAD_BITS(PB),
                        .FIFO_DEPTH(4), .AUTO_RESTART(0), .CNT_BITS(CB)) u_a (
      .clk(clk), .reset(reset), .flush(flush_a), .bus(bus_a),
      .start_req(start_req_a), .ap_start(ap_start_a), .ap_done(ap_done_a), .busy(busy_a),
      .in_count(in_count_a), .out_count(out_count_a), .run_count(run_count_a)
   );

   leaf_stream_bridge #(.NUM_IN_PORTS(1), .NUM_OUT_PORTS(1), .PAYLOAD_BITS(PB),
                        .FIFO_DEPTH(4), .AUTO_RESTART(1), .CNT_BITS(CB)) u_b (
      .clk(clk), .reset(reset), .flush(flush_b), .bus(bus_b),
      .start_req(start_req_b), .ap_start(ap_start_b), .ap_done(ap_done_b), .busy(busy_b),
      .in_count(in_count_b), .out_count(out_count_b), .run_count(run_count_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [31:0] q_in[NI][$];
   logic [31:0] q_out[NO][$];
   int          in_seq[NI], in_lim[NI], in_pop[NI];
   int          out_seq[NO], out_lim[NO], out_pop[NO];
   logic [31:0] in_base[NI], out_base[NO];
   logic [NI-1:0] usr_ack_en;
   logic [NO-1:0] ifc_ack_en;
   bit          rnd_mode;
   int          cyc = 0;
   int          first_push_o0, last_push_o0, first_pop_o0, last_pop_o0;
   int          hi, drops;

   task automatic monitor_a();
      for (int k = 0; k < NI; k++) begin
         if (bus_a.vld_to_user[k] && bus_a.ack_from_user[k]) begin
            check_eq($sformatf("in%0d_nonempty", k), 64'(q_in[k].size() > 0), 64'd1);
            if (q_in[k].size() > 0)
               check_eq($sformatf("in%0d_data", k), 64'(bus_a.dout_user[k*PB +: PB]), 64'(q_in[k].pop_front()));
            in_pop[k]++;
         end
         if (bus_a.vld_iface[k] && bus_a.ack_to_iface[k]) begin
            q_in[k].push_back(bus_a.din_iface[k*PB +: PB]);
            in_seq[k]++;
         end
      end
      for (int k = 0; k < NO; k++) begin
         if (bus_a.vld_to_iface[k] && bus_a.ack_from_iface[k]) begin
            check_eq($sformatf("out%0d_nonempty", k), 64'(q_out[k].size() > 0), 64'd1);
            if (q_out[k].size() > 0)
               check_eq($sformatf("out%0d_data", k), 64'(bus_a.dout_iface[k*PB +: PB]), 64'(q_out[k].pop_front()));
            if (k == 0 && first_pop_o0 < 0) first_pop_o0 = cyc;
            if (k == 0) last_pop_o0 = cyc;
            out_pop[k]++;
         end
         if (bus_a.vld_from_user[k] && bus_a.ack_to_user[k]) begin
            q_out[k].push_back(bus_a.din_user[k*PB +: PB]);
            if (k == 0 && first_push_o0 < 0) first_push_o0 = cyc;
            if (k == 0) last_push_o0 = cyc;
            out_seq[k]++;
         end
      end
   endtask

   task automatic drive_a();
      for (int k = 0; k < NI; k++) begin
         if (in_seq[k] < in_lim[k]) begin
            bus_a.vld_iface[k] = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_a.din_iface[k*PB +: PB] = in_base[k] + 32'(in_seq[k]);
         end else begin
            bus_a.vld_iface[k] = 1'b0;
         end
         bus_a.ack_from_user[k] = rnd_mode ? 1'($urandom_range(0, 1)) : usr_ack_en[k];
      end
      for (int k = 0; k < NO; k++) begin
         if (out_seq[k] < out_lim[k]) begin
            bus_a.vld_from_user[k] = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_a.din_user[k*PB +: PB] = out_base[k] + 32'(out_seq[k]);
         end else begin
            bus_a.vld_from_user[k] = 1'b0;
         end
         bus_a.ack_from_iface[k] = rnd_mode ? 1'($urandom_range(0, 1)) : ifc_ack_en[k];
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor_a();
      @(posedge clk);
      #1;
      cyc++;
      drive_a();
   endtask

   task automatic clear_streams();
      for (int k = 0; k < NI; k++) begin
         q_in[k].delete(); in_seq[k] = 0; in_lim[k] = 0; in_pop[k] = 0;
      end
      for (int k = 0; k < NO; k++) begin
         q_out[k].delete(); out_seq[k] = 0; out_lim[k] = 0; out_pop[k] = 0;
      end
      first_push_o0 = -1; last_push_o0 = -1; first_pop_o0 = -1; last_pop_o0 = -1;
   endtask

   task automatic do_flush_a(input string tag);
      clear_streams();
      drive_a();
      flush_a = 1'b1;
      #1;
      check_eq({tag, "_acks_low"}, 64'({bus_a.ack_to_iface, bus_a.ack_to_user}), 64'd0);
      cycle();
      flush_a = 1'b0;
      clear_streams();
   endtask

   initial begin
      flush_a = 1'b0; start_req_a = 1'b0; ap_done_a = 1'b0;
      flush_b = 1'b0; start_req_b = 1'b0; ap_done_b = 1'b0;
      bus_a.din_iface = '0; bus_a.vld_iface = '0; bus_a.ack_from_user = '0;
      bus_a.din_user = '0; bus_a.vld_from_user = '0; bus_a.ack_from_iface = '0;
      bus_b.din_iface = '0; bus_b.vld_iface = '0; bus_b.ack_from_user = '0;
      bus_b.din_user = '0; bus_b.vld_from_user = '0; bus_b.ack_from_iface = '0;
      rnd_mode = 1'b0; usr_ack_en = '0; ifc_ack_en = '0;
      for (int k = 0; k < NI; k++) in_base[k] = 32'd0;
      for (int k = 0; k < NO; k++) out_base[k] = 32'd0;
      clear_streams();

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_acks", 64'({bus_a.ack_to_iface, bus_a.ack_to_user}), 64'd0);
      check_eq("rst_valids", 64'({bus_a.vld_to_user, bus_a.vld_to_iface}), 64'd0);
      check_eq("rst_data", 64'((|bus_a.dout_user) | (|bus_a.dout_iface)), 64'd0);
      check_eq("rst_ctrl", 64'({ap_start_a, busy_a, ap_start_b, busy_b}), 64'd0);
      check_eq("rst_counts", 64'((|in_count_a) | (|out_count_a) | (|run_count_a)), 64'd0);

      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("release_acks_a", 64'({bus_a.ack_to_iface, bus_a.ack_to_user}), 64'h1F);
      check_eq("release_acks_b", 64'({bus_b.ack_to_iface, bus_b.ack_to_user}), 64'h3);

      // Fill in-port 0 with the user stalled, then drain.
      in_base[0] = 32'h11; in_lim[0] = 4;
      drive_a();
      for (int i = 0; i < 20 && in_seq[0] < 4; i++) cycle();
      check_eq("t1_accepts", 64'(in_seq[0]), 64'd4);
      check_eq("t1_full_ack", 64'(bus_a.ack_to_iface[0]), 64'd0);
      check_eq("t1_held_vld", 64'(bus_a.vld_to_user[0]), 64'd1);
      check_eq("t1_head", 64'(bus_a.dout_user[PB-1:0]), 64'h11);
      usr_ack_en[0] = 1'b1;
      drive_a();
      for (int i = 0; i < 20 && in_pop[0] < 4; i++) cycle();
      check_eq("t1_pops", 64'(in_pop[0]), 64'd4);
      check_eq("t1_empty_vld", 64'(bus_a.vld_to_user[0]), 64'd0);
      check_eq("t1_in_count", 64'(in_count_a[CB-1:0]), 64'd4);

      // 100-word stream on out-port 0; push-to-pop distance of two monitor cycles is one cycle of fall-through.
      out_base[0] = 32'd0; out_lim[0] = 100; ifc_ack_en[0] = 1'b1;
      drive_a();
      for (int i = 0; i < 300 && out_pop[0] < 100; i++) cycle();
      check_eq("t2_pops", 64'(out_pop[0]), 64'd100);
      check_eq("t2_push_rate", 64'(last_push_o0 - first_push_o0), 64'd99);
      check_eq("t2_latency", 64'(first_pop_o0 - first_push_o0), 64'd2);
      check_eq("t2_pop_rate", 64'(last_pop_o0 - first_pop_o0), 64'd99);
      check_eq("t2_out_count", 64'(out_count_a[CB-1:0]), 64'd100);
      ifc_ack_en[0] = 1'b0; usr_ack_en[0] = 1'b0;

      // Random valid/ack toggling on every port.
      do_flush_a("t3_flush");
      rnd_mode = 1'b1;
      for (int k = 0; k < NI; k++) begin in_base[k] = 32'(k) << 24; in_lim[k] = 1000; end
      for (int k = 0; k < NO; k++) begin out_base[k] = 32'h8000_0000 | (32'(k) << 24); out_lim[k] = 1000; end
      drive_a();
      for (int i = 0; i < 30000; i++) begin
         if (in_pop[0] == 1000 && in_pop[1] == 1000 && in_pop[2] == 1000 &&
             out_pop[0] == 1000 && out_pop[1] == 1000) break;
         cycle();
      end
      rnd_mode = 1'b0;
      drive_a();
      for (int k = 0; k < NI; k++) begin
         check_eq($sformatf("t3_in%0d_pops", k), 64'(in_pop[k]), 64'd1000);
         check_eq($sformatf("t3_in%0d_count", k), 64'(in_count_a[k*CB +: CB]), 64'd1000);
      end
      for (int k = 0; k < NO; k++) begin
         check_eq($sformatf("t3_out%0d_pops", k), 64'(out_pop[k]), 64'd1000);
         check_eq($sformatf("t3_out%0d_count", k), 64'(out_count_a[k*CB +: CB]), 64'd1000);
      end

      // One-shot run: ap_done 20 cycles after the start pulse.
      start_req_a = 1'b1;
      cycle();
      start_req_a = 1'b0;
      check_eq("t4_start_rise", 64'({ap_start_a, busy_a}), 64'h3);
      hi = 1;
      repeat (19) begin
         cycle();
         if (ap_start_a) hi++;
      end
      ap_done_a = 1'b1;
      cycle();
      ap_done_a = 1'b0;
      check_eq("t4_start_fall", 64'({ap_start_a, busy_a}), 64'd0);
      check_eq("t4_span", 64'(hi), 64'd20);
      check_eq("t4_runs", 64'(run_count_a), 64'd1);
      ap_done_a = 1'b1;
      cycle();
      ap_done_a = 1'b0;
      cycle();
      check_eq("t4_idle_done", 64'(run_count_a), 64'd1);
      check_eq("t4_idle_start", 64'(ap_start_a), 64'd0);

      // Auto-restart: three done pulses with start_req high, a fourth after it drops.
      start_req_b = 1'b1;
      cycle();
      check_eq("t5_start_rise", 64'(ap_start_b), 64'd1);
      drops = 0;
      for (int p = 0; p < 3; p++) begin
         repeat (4) begin
            cycle();
            if (!ap_start_b) drops++;
         end
         ap_done_b = 1'b1;
         cycle();
         ap_done_b = 1'b0;
         if (!ap_start_b) drops++;
      end
      start_req_b = 1'b0;
      repeat (3) begin
         cycle();
         if (!ap_start_b) drops++;
      end
      check_eq("t5_no_drop", 64'(drops), 64'd0);
      ap_done_b = 1'b1;
      cycle();
      ap_done_b = 1'b0;
      check_eq("t5_start_fall", 64'(ap_start_b), 64'd0);
      check_eq("t5_runs", 64'(run_count_b), 64'd4);

      // Flush with counters at 7 and FIFOs half-full.
      do_flush_a("t6_pre_flush");
      usr_ack_en[0] = 1'b1; ifc_ack_en[0] = 1'b1;
      in_base[0] = 32'h100; out_base[0] = 32'h200;
      in_lim[0] = 7; out_lim[0] = 7;
      drive_a();
      for (int i = 0; i < 50 && (in_pop[0] < 7 || out_pop[0] < 7); i++) cycle();
      check_eq("t6_in_count7", 64'(in_count_a[CB-1:0]), 64'd7);
      check_eq("t6_out_count7", 64'(out_count_a[CB-1:0]), 64'd7);
      usr_ack_en[0] = 1'b0; ifc_ack_en[0] = 1'b0;
      in_lim[0] = 9; out_lim[0] = 9;
      drive_a();
      for (int i = 0; i < 50 && (in_seq[0] < 9 || out_seq[0] < 9); i++) cycle();
      cycle();
      check_eq("t6_half_vld", 64'({bus_a.vld_to_user[0], bus_a.vld_to_iface[0]}), 64'h3);
      start_req_a = 1'b1;
      cycle();
      start_req_a = 1'b0;
      do_flush_a("t6_flush");
      check_eq("t6_valids", 64'({bus_a.vld_to_user, bus_a.vld_to_iface}), 64'd0);
      check_eq("t6_counts", 64'((|in_count_a) | (|out_count_a) | (|run_count_a)), 64'd0);
      check_eq("t6_fsm_kept", 64'(ap_start_a), 64'd1);

      // Asynchronous reset in the middle of a random burst.
      rnd_mode = 1'b1;
      for (int k = 0; k < NI; k++) in_lim[k] = 50;
      for (int k = 0; k < NO; k++) out_lim[k] = 50;
      drive_a();
      repeat (10) cycle();
      #2;
      reset = 1'b0;
      #1;
      check_eq("t7_acks", 64'({bus_a.ack_to_iface, bus_a.ack_to_user}), 64'd0);
      check_eq("t7_valids", 64'({bus_a.vld_to_user, bus_a.vld_to_iface}), 64'd0);
      check_eq("t7_data", 64'((|bus_a.dout_user) | (|bus_a.dout_iface)), 64'd0);
      check_eq("t7_ctrl", 64'({ap_start_a, busy_a, ap_start_b, busy_b}), 64'd0);
      check_eq("t7_counts", 64'((|in_count_a) | (|out_count_a) | (|run_count_a) | (|run_count_b)), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
